ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS core.
- Captures ALU results, store data, destination and control bits at each rising clk edge.
- Supports stall (hold) and flush (bubble insertion), and exports forwarding info for the hazard unit.
- Keeps saturating stall and bubble counters for debug.

Parameters:
- DATA_W, 32, datapath width (address, store data, branch target)
- REG_AW, 5, register-file index width
- CNT_W, 16, width of the stall and bubble counters

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all registered contents this cycle
- flush  in  1  load a bubble this cycle
- in_valid  in  1  EX holds a real instruction
- in_alu_result  in  DATA_W  EX ALU output / memory address
- in_write_data  in  DATA_W  store data (rt after forwarding)
- in_branch_target  in  DATA_W  computed branch target
- in_write_back_destination  in  REG_AW  destination register
- in_mem_to_reg, in_mem_write, in_mem_read, in_reg_write, in_branch, in_zero  in  1 each  control bits
- in_load_mode  in  2  00 word, 01 half signed, 10 byte signed, 11 byte unsigned
- valid_out  out  1  registered valid
- address_out  out  DATA_W  registered ALU result
- write_data_out  out  DATA_W  registered store data
- branch_target_out  out  DATA_W  registered branch target
- write_back_destination_out  out  REG_AW  registered destination
- mem_to_reg_out, mem_write_out, mem_read_out, reg_write_out, branch_out, zero_out  out  1 each
- load_mode_out  out  2  registered load mode
- pc_src  out  1  combinational: valid_out & branch_out & zero_out
- fwd_reg_write  out  1  valid_out & reg_write_out & (write_back_destination_out != 0)
- fwd_is_load  out  1  valid_out & mem_read_out
- stall_count  out  CNT_W  cycles with stall=1 and flush=0, saturating
- bubble_count  out  CNT_W  bubbles loaded by flush, saturating
- misalign_out  out  1  present only with the optional feature

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0. This covers all data fields, control bits, valid, counters and misalign_out. pc_src, fwd_reg_write and fwd_is_load are therefore 0.
- Priority at each rising clk edge (rst_n=1): flush, then stall, then load.
- Load (flush=0, stall=0):
  - All out_* fields take the in_* values.
  - Latency is exactly one cycle.
- Stall (stall=1, flush=0):
  - Every registered field holds its value.
  - stall_count increments.
- Flush (flush=1, regardless of stall):
  - valid, mem_to_reg, mem_write, mem_read, reg_write, branch, zero and load_mode are cleared.
  - The data fields (address, write_data, branch_target) are zeroed.
  - write_back_destination is set to 0.
  - bubble_count increments.
  - stall_count does not increment.
- Invalid input (in_valid=0 on a load): registered like a flush, but bubble_count does not increment.
- Counters:
  - Each counter saturates at all-ones (2^CNT_W-1) and never wraps.
  - Counters are cleared only by reset.
- Forwarding and branch outputs are pure combinational functions of registered state. Inputs never reach outputs in the same cycle.
- Destination register 0 never asserts fwd_reg_write.
- If rst_n is asserted mid-stall, outputs clear immediately. At deassertion the first edge performs a normal load.

Optional Feature:
- Macro: EX_MEM_ALIGN_CHECK_EN.
- With the macro defined, the load path computes a misalignment check:
  - misaligned = (in_mem_read | in_mem_write) & ((in_load_mode==00 & in_alu_result[1:0]!=0) | (in_load_mode==01 & in_alu_result[0]!=0)).
  - If misaligned, mem_read_out, mem_write_out and reg_write_out register as 0 and misalign_out registers 1. All other fields load normally.
  - misalign_out clears on the next load or flush, and holds on stall.
- Without the macro: no check is made, the misalign_out port is absent, and memory controls pass through unmodified.

Test Plan:
- Reset then load: pulse rst_n low, then load in_alu_result=0x0000_0010, in_write_data=0xDEAD_BEEF, dest=5, reg_write=1, in_valid=1 -> all outputs 0 during reset. One edge after release: address_out=0x10, write_data_out=0xDEADBEEF, fwd_reg_write=1.
- Stall hold: load dest=7 then assert stall for 3 cycles while the inputs change -> outputs keep dest=7 and stall_count=3.
- Flush beats stall: stall=1 and flush=1 together with in_mem_write=1 -> mem_write_out=0, valid_out=0, bubble_count=1, stall_count unchanged.
- Branch resolve: load branch=1, zero=1, target=0x0000_0040 -> pc_src=1 and branch_target_out=0x40. Then load branch=1, zero=0 -> pc_src=0.
- Register 0 and counter saturation: load dest=0 with reg_write=1 -> fwd_reg_write=0. With CNT_W=4, hold stall for 20 cycles -> stall_count sticks at 15.
- With EX_MEM_ALIGN_CHECK_EN: mem_read=1, load_mode=00, address 0x0000_0006 -> mem_read_out=0, misalign_out=1. Then mode 01 with address 0x6 -> mem_read_out=1, misalign_out=0.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush control, forwarding exports and saturating debug counters.
// Optional alignment check on memory accesses is enabled by defining EX_MEM_ALIGN_CHECK_EN.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic [DATA_W-1:0] in_branch_target,
    input  logic [REG_AW-1:0] in_write_back_destination,
    input  logic              in_mem_to_reg,
    input  logic              in_mem_write,
    input  logic              in_mem_read,
    input  logic              in_reg_write,
    input  logic              in_branch,
    input  logic              in_zero,
    input  logic [1:0]        in_load_mode,
    output logic              valid_out,
    output logic [DATA_W-1:0] address_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic [DATA_W-1:0] branch_target_out,
    output logic [REG_AW-1:0] write_back_destination_out,
    output logic              mem_to_reg_out,
    output logic              mem_write_out,
    output logic              mem_read_out,
    output logic              reg_write_out,
    output logic              branch_out,
    output logic              zero_out,
    output logic [1:0]        load_mode_out,
    output logic              pc_src,
    output logic              fwd_reg_write,
    output logic              fwd_is_load,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  bubble_count
`ifdef EX_MEM_ALIGN_CHECK_EN
    ,
    output logic              misalign_out
`endif
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] btgt_q, btgt_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              m2r_q, m2r_d;
    logic              mwr_q, mwr_d;
    logic              mrd_q, mrd_d;
    logic              rwr_q, rwr_d;
    logic              br_q, br_d;
    logic              zero_q, zero_d;
    logic [1:0]        lmode_q, lmode_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

`ifdef EX_MEM_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic misaligned;

    assign misaligned = (in_mem_read | in_mem_write) &
                        (((in_load_mode == 2'b00) & (in_alu_result[1:0] != 2'b00)) |
                         ((in_load_mode == 2'b01) & in_alu_result[0]));
`endif

    always_comb begin
        valid_d      = valid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        btgt_d       = btgt_q;
        dest_d       = dest_q;
        m2r_d        = m2r_q;
        mwr_d        = mwr_q;
        mrd_d        = mrd_q;
        rwr_d        = rwr_q;
        br_d         = br_q;
        zero_d       = zero_q;
        lmode_d      = lmode_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
`ifdef EX_MEM_ALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif
        if (flush || (!stall && !in_valid)) begin
            // Bubble: flush, or a load of an empty EX slot.
            valid_d = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            btgt_d  = '0;
            dest_d  = '0;
            m2r_d   = 1'b0;
            mwr_d   = 1'b0;
            mrd_d   = 1'b0;
            rwr_d   = 1'b0;
            br_d    = 1'b0;
            zero_d  = 1'b0;
            lmode_d = 2'b00;
`ifdef EX_MEM_ALIGN_CHECK_EN
            misalign_d = 1'b0;
`endif
            if (flush && (bubble_cnt_q != '1))
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else if (stall) begin
            if (stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            valid_d = 1'b1;
            addr_d  = in_alu_result;
            wdata_d = in_write_data;
            btgt_d  = in_branch_target;
            dest_d  = in_write_back_destination;
            m2r_d   = in_mem_to_reg;
            mwr_d   = in_mem_write;
            mrd_d   = in_mem_read;
            rwr_d   = in_reg_write;
            br_d    = in_branch;
            zero_d  = in_zero;
            lmode_d = in_load_mode;
`ifdef EX_MEM_ALIGN_CHECK_EN
            misalign_d = misaligned;
            if (misaligned) begin
                mwr_d = 1'b0;
                mrd_d = 1'b0;
                rwr_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            btgt_q       <= '0;
            dest_q       <= '0;
            m2r_q        <= 1'b0;
            mwr_q        <= 1'b0;
            mrd_q        <= 1'b0;
            rwr_q        <= 1'b0;
            br_q         <= 1'b0;
            zero_q       <= 1'b0;
            lmode_q      <= 2'b00;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
`ifdef EX_MEM_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            btgt_q       <= btgt_d;
            dest_q       <= dest_d;
            m2r_q        <= m2r_d;
            mwr_q        <= mwr_d;
            mrd_q        <= mrd_d;
            rwr_q        <= rwr_d;
            br_q         <= br_d;
            zero_q       <= zero_d;
            lmode_q      <= lmode_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
`ifdef EX_MEM_ALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign valid_out                  = valid_q;
    assign address_out                = addr_q;
    assign write_data_out             = wdata_q;
    assign branch_target_out          = btgt_q;
    assign write_back_destination_out = dest_q;
    assign mem_to_reg_out             = m2r_q;
    assign mem_write_out              = mwr_q;
    assign mem_read_out               = mrd_q;
    assign reg_write_out              = rwr_q;
    assign branch_out                 = br_q;
    assign zero_out                   = zero_q;
    assign load_mode_out              = lmode_q;
    assign stall_count                = stall_cnt_q;
    assign bubble_count               = bubble_cnt_q;
`ifdef EX_MEM_ALIGN_CHECK_EN
    assign misalign_out               = misalign_q;
`endif

    // Hazard-unit exports depend only on registered state.
    assign pc_src        = valid_q & br_q & zero_q;
    assign fwd_reg_write = valid_q & rwr_q & (dest_q != '0);
    assign fwd_is_load   = valid_q & mrd_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized and directed bench for ex_mem_reg against a field-level reference model.
module tb_ex_mem_reg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] in_alu_result = '0, in_write_data = '0, in_branch_target = '0;
    logic [AW-1:0] in_write_back_destination = '0;
    logic in_mem_to_reg = 0, in_mem_write = 0, in_mem_read = 0, in_reg_write = 0, in_branch = 0, in_zero = 0;
    logic [1:0] in_load_mode = '0;

    logic valid_out, mem_to_reg_out, mem_write_out, mem_read_out, reg_write_out, branch_out, zero_out;
    logic [DW-1:0] address_out, write_data_out, branch_target_out;
    logic [AW-1:0] write_back_destination_out;
    logic [1:0] load_mode_out;
    logic pc_src, fwd_reg_write, fwd_is_load;
    logic [CW-1:0] stall_count, bubble_count;
    logic misalign_obs;

    always #5 clk = ~clk;

    ex_mem_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_alu_result(in_alu_result), .in_write_data(in_write_data),
        .in_branch_target(in_branch_target), .in_write_back_destination(in_write_back_destination),
        .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
        .in_reg_write(in_reg_write), .in_branch(in_branch), .in_zero(in_zero),
        .in_load_mode(in_load_mode),
        .valid_out(valid_out), .address_out(address_out), .write_data_out(write_data_out),
        .branch_target_out(branch_target_out), .write_back_destination_out(write_back_destination_out),
        .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out), .mem_read_out(mem_read_out),
        .reg_write_out(reg_write_out), .branch_out(branch_out), .zero_out(zero_out),
        .load_mode_out(load_mode_out), .pc_src(pc_src), .fwd_reg_write(fwd_reg_write),
        .fwd_is_load(fwd_is_load), .stall_count(stall_count), .bubble_count(bubble_count)
`ifdef EX_MEM_ALIGN_CHECK_EN
        , .misalign_out(misalign_obs)
`endif
    );
`ifndef EX_MEM_ALIGN_CHECK_EN
    assign misalign_obs = 1'b0;
`endif

    // Reference model: one record of what the MEM stage should currently see.
    typedef struct {
        logic v; logic [DW-1:0] a, w, b; logic [AW-1:0] d;
        logic m2r, mw, mr, rw, br, z; logic [1:0] lm; logic mis;
        int sc, bc;
    } mdl_t;
    mdl_t m;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic void model_clear();
        m.v = 0; m.a = '0; m.w = '0; m.b = '0; m.d = '0;
        m.m2r = 0; m.mw = 0; m.mr = 0; m.rw = 0; m.br = 0; m.z = 0; m.lm = '0; m.mis = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m.sc = 0; m.bc = 0;
    endfunction

    function automatic void model_step();
        logic bad;
        if (flush) begin
            model_clear();
            m.bc = (m.bc < CMAX) ? m.bc + 1 : CMAX;
        end else if (stall) begin
            m.sc = (m.sc < CMAX) ? m.sc + 1 : CMAX;
        end else if (!in_valid) begin
            model_clear();
        end else begin
            m.v = 1; m.a = in_alu_result; m.w = in_write_data; m.b = in_branch_target;
            m.d = in_write_back_destination; m.m2r = in_mem_to_reg; m.mw = in_mem_write;
            m.mr = in_mem_read; m.rw = in_reg_write; m.br = in_branch; m.z = in_zero;
            m.lm = in_load_mode; m.mis = 0;
`ifdef EX_MEM_ALIGN_CHECK_EN
            // Word accesses need a 4-byte aligned address, halfwords a 2-byte one.
            bad = (in_mem_read || in_mem_write) &&
                  ((in_load_mode == 2'd0 && (in_alu_result % 4) != 0) ||
                   (in_load_mode == 2'd1 && (in_alu_result % 2) != 0));
            if (bad) begin m.mr = 0; m.mw = 0; m.rw = 0; m.mis = 1; end
`else
            bad = 0;
`endif
        end
    endfunction

    task automatic check_all();
        check("valid", valid_out, m.v);
        check("address", address_out, m.a);
        check("write_data", write_data_out, m.w);
        check("branch_target", branch_target_out, m.b);
        check("dest", write_back_destination_out, m.d);
        check("mem_to_reg", mem_to_reg_out, m.m2r);
        check("mem_write", mem_write_out, m.mw);
        check("mem_read", mem_read_out, m.mr);
        check("reg_write", reg_write_out, m.rw);
        check("branch", branch_out, m.br);
        check("zero", zero_out, m.z);
        check("load_mode", load_mode_out, m.lm);
        check("pc_src", pc_src, m.v && m.br && m.z);
        check("fwd_reg_write", fwd_reg_write, m.v && m.rw && (m.d != 0));
        check("fwd_is_load", fwd_is_load, m.v && m.mr);
        check("stall_count", stall_count, m.sc);
        check("bubble_count", bubble_count, m.bc);
`ifdef EX_MEM_ALIGN_CHECK_EN
        check("misalign", misalign_obs, m.mis);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] w, input logic [AW-1:0] d,
                         input logic rw, input logic mr, input logic mw, input logic [1:0] lm);
        in_valid = 1; in_alu_result = a; in_write_data = w; in_write_back_destination = d;
        in_reg_write = rw; in_mem_read = mr; in_mem_write = mw; in_load_mode = lm;
        in_mem_to_reg = mr; in_branch = 0; in_zero = 0; in_branch_target = '0;
    endtask

    initial begin
        model_reset();
        // Reset, then first load.
        drive(32'h0000_0010, 32'hDEAD_BEEF, 5'd5, 1, 0, 0, 2'b00);
        #12;
        check_all();
        rst_n = 1;
        tick();
        check("first_addr", address_out, 32'h10);
        check("first_wdata", write_data_out, 32'hDEAD_BEEF);
        check("first_fwd", fwd_reg_write, 1'b1);

        // Stall hold while inputs change.
        drive(32'h100, 32'h1, 5'd7, 1, 0, 0, 2'b00);
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 5'($urandom_range(1, 31)), 1, 1, 1, 2'($urandom));
            tick();
        end
        check("stall_dest", write_back_destination_out, 5'd7);
        check("stall_cnt3", stall_count, 4'd3);

        // Flush wins over stall.
        flush = 1; in_mem_write = 1;
        tick();
        check("flush_mw", mem_write_out, 1'b0);
        check("flush_valid", valid_out, 1'b0);
        check("flush_bubble", bubble_count, 4'd1);
        check("flush_stallcnt", stall_count, 4'd3);
        flush = 0; stall = 0;

        // Branch resolution.
        drive(32'h8, 32'h0, 5'd0, 0, 0, 0, 2'b00);
        in_branch = 1; in_zero = 1; in_branch_target = 32'h40;
        tick();
        check("br_taken", pc_src, 1'b1);
        check("br_target", branch_target_out, 32'h40);
        in_zero = 0;
        tick();
        check("br_not_taken", pc_src, 1'b0);

        // Register 0 never forwards; stall counter saturates.
        drive(32'h20, 32'h5, 5'd0, 1, 0, 0, 2'b00);
        tick();
        check("r0_fwd", fwd_reg_write, 1'b0);
        stall = 1;
        for (int i = 0; i < 20; i++) tick();
        check("stall_sat", stall_count, 4'd15);
        stall = 0;

`ifdef EX_MEM_ALIGN_CHECK_EN
        drive(32'h6, 32'h0, 5'd3, 1, 1, 0, 2'b00);
        tick();
        check("align_word_mr", mem_read_out, 1'b0);
        check("align_word_mis", misalign_obs, 1'b1);
        in_load_mode = 2'b01;
        tick();
        check("align_half_mr", mem_read_out, 1'b1);
        check("align_half_mis", misalign_obs, 1'b0);
`endif

        // Reset asserted mid-stall clears at once; first edge after release loads.
        drive(32'hABCD_0000, 32'h1234, 5'd9, 1, 0, 0, 2'b00);
        tick();
        stall = 1;
        tick();
        #2 rst_n = 0;
        #1 model_reset();
        check_all();
        check("midrst_addr", address_out, 32'h0);
        #2 rst_n = 1;
        stall = 0;
        drive(32'h0000_0044, 32'h55, 5'd12, 1, 0, 0, 2'b00);
        tick();
        check("post_rst_addr", address_out, 32'h44);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            in_valid = ($urandom_range(0, 4) != 0);
            in_alu_result = $urandom; in_write_data = $urandom; in_branch_target = $urandom;
            in_write_back_destination = 5'($urandom_range(0, 7));
            in_mem_to_reg = 1'($urandom); in_mem_write = 1'($urandom); in_mem_read = 1'($urandom);
            in_reg_write = 1'($urandom); in_branch = 1'($urandom); in_zero = 1'($urandom);
            in_load_mode = 2'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
